// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared width, feedback tap positions and state type for the 4-bit LFSR.
package lfsr_pkg;
    localparam int LFSR_WIDTH = 4;
    localparam int TAP_A = 0;
    localparam int TAP_B = 1;
    typedef logic [LFSR_WIDTH-1:0] lfsr_state_t;
endpackage

// File: rtl/lfsr_bit_cell.sv
// lfsr_bit_cell: 2:1 mux (seed bit vs shift-in bit) feeding one async-reset D flip-flop.
module lfsr_bit_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sel,
    input  logic seed_bit,
    input  logic shift_in,
    output logic q
);
    logic q_d, q_q;
    assign q_d = sel ? seed_bit : shift_in;
    always_ff @(posedge clk or posedge reset)
        if (reset) q_q <= RST_VAL;
        else q_q <= q_d;
    assign q = q_q;
endmodule

// File: rtl/lfsr_struct.sv
// lfsr_struct: 4-bit Fibonacci LFSR (x^4 + x^3 + 1) with synchronous seed load.
// Define LFSR_LOCKUP_RECOVER_EN to make the all-zero state step to 0001 instead of sticking.
module lfsr_struct
    import lfsr_pkg::*;
#(
    parameter lfsr_state_t RESET_VALUE = 4'b0000
) (
    input  lfsr_state_t seed,
    input  logic        sel,
    input  logic        reset,
    input  logic        clk,
    output lfsr_state_t state
);
    lfsr_state_t state_q, shift_d;
    logic fb;
    assign fb = state_q[TAP_A] ^ state_q[TAP_B];
`ifdef LFSR_LOCKUP_RECOVER_EN
    assign shift_d = {fb, state_q[LFSR_WIDTH-1:1]} | {{(LFSR_WIDTH-1){1'b0}}, state_q == '0};
`else
    assign shift_d = {fb, state_q[LFSR_WIDTH-1:1]};
`endif
    for (genvar g = 0; g < LFSR_WIDTH; g++) begin : g_cell
        lfsr_bit_cell #(.RST_VAL(RESET_VALUE[g])) u_cell (
            .clk     (clk),
            .reset   (reset),
            .sel     (sel),
            .seed_bit(seed[g]),
            .shift_in(shift_d[g]),
            .q       (state_q[g])
        );
    end
    assign state = state_q;
endmodule

// File: tb/tb_lfsr_struct.sv
// tb_lfsr_struct: randomized self-checking bench for lfsr_struct against an arithmetic LFSR model.
module tb_lfsr_struct;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] seed = 4'h0;
    logic [3:0] state;
    int tests = 0;
    int fails = 0;
    logic [3:0] model;

    lfsr_struct dut (
        .seed (seed),
        .sel  (sel),
        .reset(reset),
        .clk  (clk),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] nxt(input logic [3:0] s);
        int v;
        v = int'(s);
        if (v == 0) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            return 4'd1;
`else
            return 4'd0;
`endif
        end
        return 4'((v >> 1) + (((v ^ (v >> 1)) % 2) * 8));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel = 1'bx;
        seed = 4'bxxxx;
        #2 reset = 1'b1;
        #1;
        tests++;
        if (state !== 4'h0) begin
            fails++;
            $display("FAIL reset_async got=%b want=0000", state);
        end
        tick();
        tests++;
        if (state !== 4'h0) begin
            fails++;
            $display("FAIL reset_hold got=%b want=0000", state);
        end
        reset = 1'b0;
        sel = 1'b0;
        seed = 4'h0;
        model = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            model = nxt(model);
            tests++;
            if (state !== model) begin
                fails++;
                $display("FAIL reset_release[%0d] got=%b want=%b", i, state, model);
            end
        end
    endtask

    task automatic load(input logic [3:0] s);
        sel = 1'b1;
        seed = s;
        tick();
        sel = 1'b0;
        seed = 4'($urandom);
        model = s;
        tests++;
        if (state !== s) begin
            fails++;
            $display("FAIL load got=%b want=%b", state, s);
        end
    endtask

    task automatic test_period();
        logic [3:0] exp_seq [16] = '{4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b0100, 4'b0010,
                                     4'b1001, 4'b1100, 4'b0110, 4'b1011, 4'b0101, 4'b1010,
                                     4'b1101, 4'b1110, 4'b1111, 4'b0111};
        load(4'b1111);
        for (int i = 0; i < 16; i++) begin
            tick();
            model = nxt(model);
            tests++;
            if (state !== exp_seq[i] || state !== model) begin
                fails++;
                $display("FAIL period[%0d] got=%b want=%b", i, state, exp_seq[i]);
            end
        end
    endtask

    task automatic test_loads();
        logic [3:0] seeds [2] = '{4'b1010, 4'b1001};
        logic [3:0] heads [2][4] = '{'{4'b1101, 4'b1110, 4'b1111, 4'b0111},
                                     '{4'b1100, 4'b0110, 4'b1011, 4'b0101}};
        for (int k = 0; k < 2; k++) begin
            load(seeds[k]);
            for (int i = 0; i < 4; i++) begin
                tick();
                tests++;
                if (state !== heads[k][i]) begin
                    fails++;
                    $display("FAIL load_seq%0d[%0d] got=%b want=%b", k, i, state, heads[k][i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        load(4'b0110);
        tick();
        tick();
        #2;
        reset = 1'b1;
        sel = 1'b1;
        seed = 4'b1011;
        #1;
        tests++;
        if (state !== 4'h0) begin
            fails++;
            $display("FAIL async_mid got=%b want=0000", state);
        end
        tick();
        tests++;
        if (state !== 4'h0) begin
            fails++;
            $display("FAIL reset_beats_sel got=%b want=0000", state);
        end
        reset = 1'b0;
        sel = 1'b0;
        model = 4'h0;
    endtask

    task automatic test_lockup();
        load(4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            model = nxt(model);
            tests++;
            if (state !== model) begin
                fails++;
                $display("FAIL lockup[%0d] got=%b want=%b", i, state, model);
            end
        end
    endtask

    task automatic test_random();
        load(4'($urandom_range(1, 15)));
        for (int i = 0; i < 300; i++) begin
            sel = ($urandom_range(0, 3) == 0);
            seed = 4'($urandom);
            tick();
            model = sel ? seed : nxt(model);
            tests++;
            if (state !== model) begin
                fails++;
                $display("FAIL random[%0d] sel=%b seed=%b got=%b want=%b", i, sel, seed, state, model);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_period();
        test_loads();
        test_async_reset();
        test_lockup();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
